// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard controller: forward-select codes, GPR
// address width and the producer/consumer register match rule.
package hazard_control_unit_pkg;

  localparam int GPR_ADDRESS_WIDTH = 5;

  typedef enum logic [1:0] {
    FORWARD_REGISTER_FILE = 2'b00,
    FORWARD_MEMORY        = 2'b01,
    FORWARD_WRITEBACK     = 2'b10
  } forward_select_t;

  // Register 0 is hardwired to zero, so it can never be a real dependency.
  function automatic logic register_match(
    input logic [GPR_ADDRESS_WIDTH-1:0] source_address,
    input logic                         source_used,
    input logic                         producer_write,
    input logic [GPR_ADDRESS_WIDTH-1:0] producer_address
  );
    return source_used && producer_write &&
           (source_address != '0) && (source_address == producer_address);
  endfunction

endpackage

// File: rtl/hazard_control_unit_forwarding_select.sv
// Operand forward select for one EX read port; the younger MEM-stage result
// wins over the WB-stage result.
module forwarding_select
  import hazard_control_unit_pkg::*;
(
  input  logic [GPR_ADDRESS_WIDTH-1:0] read_address,
  input  logic                         read_used,
  input  logic                         memory_register_write,
  input  logic [GPR_ADDRESS_WIDTH-1:0] memory_write_address,
  input  logic                         writeback_register_write,
  input  logic [GPR_ADDRESS_WIDTH-1:0] writeback_write_address,
  output logic [1:0]                   select
);

  forward_select_t select_code;

  always_comb begin
    select_code = FORWARD_REGISTER_FILE;
    if (register_match(read_address, read_used, memory_register_write, memory_write_address)) begin
      select_code = FORWARD_MEMORY;
    end else if (register_match(read_address, read_used, writeback_register_write,
                                writeback_write_address)) begin
      select_code = FORWARD_WRITEBACK;
    end
  end

  assign select = select_code;

endmodule

// File: rtl/hazard_control_unit.sv
// Central hazard controller for the 5-stage pipeline: load-use stall, EX
// forwarding selects, registered redirect flush and memory-wait freeze.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int READ_PORTS    = 2,
  parameter int FLUSH_DEPTH   = 3,
  parameter int MEM_TIMEOUT   = 64,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                                    system_clock,
  input  logic                                    reset,
  input  logic [GPR_ADDRESS_WIDTH*READ_PORTS-1:0] decode_read_address,
  input  logic [READ_PORTS-1:0]                   decode_read_used,
  input  logic [GPR_ADDRESS_WIDTH*READ_PORTS-1:0] execution_read_address,
  input  logic [READ_PORTS-1:0]                   execution_read_used,
  input  logic                                    execution_register_write,
  input  logic                                    execution_memory_read,
  input  logic [GPR_ADDRESS_WIDTH-1:0]            execution_write_address,
  input  logic                                    memory_register_write,
  input  logic [GPR_ADDRESS_WIDTH-1:0]            memory_write_address,
  input  logic                                    writeback_register_write,
  input  logic [GPR_ADDRESS_WIDTH-1:0]            writeback_write_address,
  input  logic                                    redirect,
  input  logic                                    memory_request,
  input  logic                                    memory_ready,
  output logic                                    stall_fetch_decode,
  output logic                                    bubble_execution,
  output logic                                    hold_all,
  output logic [FLUSH_DEPTH-1:0]                  flush,
  output logic [2*READ_PORTS-1:0]                 forward_select,
  output logic                                    memory_timeout,
  output logic [COUNTER_WIDTH-1:0]                stall_cycles,
  output logic [COUNTER_WIDTH-1:0]                flush_events
);

  localparam int WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0]    WAIT_LIMIT  = WAIT_WIDTH'(MEM_TIMEOUT);
  localparam logic [WAIT_WIDTH-1:0]    WAIT_LAST   = WAIT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX = '1;

  logic                  load_use;
  logic                  redirect_pending;
  logic                  redirect_request;
  logic [WAIT_WIDTH-1:0] wait_count;

  assign hold_all = memory_request & ~memory_ready;

  always_comb begin
    load_use = 1'b0;
    if (execution_memory_read) begin
      for (int i = 0; i < READ_PORTS; i++) begin
        if (register_match(decode_read_address[GPR_ADDRESS_WIDTH*i +: GPR_ADDRESS_WIDTH],
                           decode_read_used[i], execution_register_write,
                           execution_write_address)) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // A flushed or frozen pipeline has nothing meaningful to stall.
  assign stall_fetch_decode = load_use & ~hold_all & ~(|flush);
  assign bubble_execution   = load_use & ~hold_all & ~(|flush);

  generate
    for (genvar port = 0; port < READ_PORTS; port++) begin : gen_forward
      forwarding_select u_forwarding_select (
        .read_address             (execution_read_address[GPR_ADDRESS_WIDTH*port +: GPR_ADDRESS_WIDTH]),
        .read_used                (execution_read_used[port]),
        .memory_register_write    (memory_register_write),
        .memory_write_address     (memory_write_address),
        .writeback_register_write (writeback_register_write),
        .writeback_write_address  (writeback_write_address),
        .select                   (forward_select[2*port +: 2])
      );
    end
  endgenerate

  assign redirect_request = redirect | redirect_pending;

  // A redirect seen while frozen is parked and replayed on the first free cycle.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      flush            <= '0;
      redirect_pending <= 1'b0;
      wait_count       <= '0;
      memory_timeout   <= 1'b0;
      stall_cycles     <= '0;
      flush_events     <= '0;
    end else begin
      if (hold_all) begin
        flush <= '0;
        if (redirect) begin
          redirect_pending <= 1'b1;
        end
      end else begin
        flush            <= {FLUSH_DEPTH{redirect_request}};
        redirect_pending <= 1'b0;
        if (redirect_request && flush_events != COUNTER_MAX) begin
          flush_events <= flush_events + COUNTER_WIDTH'(1);
        end
      end

      if ((stall_fetch_decode || hold_all) && stall_cycles != COUNTER_MAX) begin
        stall_cycles <= stall_cycles + COUNTER_WIDTH'(1);
      end

      if (hold_all) begin
        if (wait_count != WAIT_LIMIT) begin
          wait_count <= wait_count + WAIT_WIDTH'(1);
        end
        if (wait_count >= WAIT_LAST) begin
          memory_timeout <= 1'b1;
        end
      end else begin
        wait_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: a cycle-level reference model
// compared every cycle, plus directed scenarios with hand-computed values.
module tb_hazard_control_unit;

  localparam int RP  = 2;
  localparam int FD  = 3;
  localparam int MT  = 8;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          system_clock;
  logic          reset;
  logic [5*RP-1:0] decode_read_address;
  logic [RP-1:0]   decode_read_used;
  logic [5*RP-1:0] execution_read_address;
  logic [RP-1:0]   execution_read_used;
  logic          execution_register_write;
  logic          execution_memory_read;
  logic [4:0]    execution_write_address;
  logic          memory_register_write;
  logic [4:0]    memory_write_address;
  logic          writeback_register_write;
  logic [4:0]    writeback_write_address;
  logic          redirect;
  logic          memory_request;
  logic          memory_ready;
  logic          stall_fetch_decode;
  logic          bubble_execution;
  logic          hold_all;
  logic [FD-1:0] flush;
  logic [2*RP-1:0] forward_select;
  logic          memory_timeout;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  int total = 0;
  int bad = 0;

  bit model_valid = 0;
  bit m_flush_on  = 0;
  bit m_pending   = 0;
  bit m_timeout   = 0;
  int m_hold_run  = 0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  hazard_control_unit #(
    .READ_PORTS    (RP),
    .FLUSH_DEPTH   (FD),
    .MEM_TIMEOUT   (MT),
    .COUNTER_WIDTH (CW)
  ) dut (
    .system_clock             (system_clock),
    .reset                    (reset),
    .decode_read_address      (decode_read_address),
    .decode_read_used         (decode_read_used),
    .execution_read_address   (execution_read_address),
    .execution_read_used      (execution_read_used),
    .execution_register_write (execution_register_write),
    .execution_memory_read    (execution_memory_read),
    .execution_write_address  (execution_write_address),
    .memory_register_write    (memory_register_write),
    .memory_write_address     (memory_write_address),
    .writeback_register_write (writeback_register_write),
    .writeback_write_address  (writeback_write_address),
    .redirect                 (redirect),
    .memory_request           (memory_request),
    .memory_ready             (memory_ready),
    .stall_fetch_decode       (stall_fetch_decode),
    .bubble_execution         (bubble_execution),
    .hold_all                 (hold_all),
    .flush                    (flush),
    .forward_select           (forward_select),
    .memory_timeout           (memory_timeout),
    .stall_cycles             (stall_cycles),
    .flush_events             (flush_events)
  );

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_hold();
    return memory_request && !memory_ready;
  endfunction

  function automatic bit exp_load_use();
    bit hit = 0;
    for (int i = 0; i < RP; i++) begin
      if (execution_memory_read && execution_register_write && execution_write_address != 0 &&
          decode_read_used[i] && decode_read_address[5*i +: 5] == execution_write_address)
        hit = 1;
    end
    return hit;
  endfunction

  function automatic bit exp_stall();
    return exp_load_use() && !exp_hold() && !m_flush_on;
  endfunction

  function automatic logic [2*RP-1:0] exp_forward();
    logic [2*RP-1:0] result = '0;
    int addr;
    for (int i = 0; i < RP; i++) begin
      addr = int'(execution_read_address[5*i +: 5]);
      if (execution_read_used[i] && addr != 0) begin
        if (memory_register_write && addr == int'(memory_write_address))
          result[2*i +: 2] = 2'd1;
        else if (writeback_register_write && addr == int'(writeback_write_address))
          result[2*i +: 2] = 2'd2;
      end
    end
    return result;
  endfunction

  // Reference model: state advances on each rising edge from the sampled inputs.
  always @(posedge system_clock) begin
    bit hold, fire, stall;
    hold  = exp_hold();
    stall = exp_stall();
    if (reset) begin
      model_valid = 1;
      m_flush_on  = 0;
      m_pending   = 0;
      m_timeout   = 0;
      m_hold_run  = 0;
      m_stalls    = 0;
      m_flushes   = 0;
    end else if (model_valid) begin
      fire = (redirect || m_pending) && !hold;
      m_pending  = hold ? (m_pending || redirect) : 0;
      m_flush_on = fire;
      if (fire) m_flushes = (m_flushes + 1 > CMAX) ? CMAX : m_flushes + 1;
      if (stall || hold) m_stalls = (m_stalls + 1 > CMAX) ? CMAX : m_stalls + 1;
      m_hold_run = hold ? ((m_hold_run + 1 > MT) ? MT : m_hold_run + 1) : 0;
      if (m_hold_run >= MT) m_timeout = 1;
    end
  end

  always @(negedge system_clock) begin
    if (model_valid) begin
      check_output("cyc_hold_all", hold_all, exp_hold());
      check_output("cyc_stall", stall_fetch_decode, exp_stall());
      check_output("cyc_bubble", bubble_execution, exp_stall());
      check_output("cyc_flush", flush, m_flush_on ? 32'h7 : 32'h0);
      check_output("cyc_forward", forward_select, exp_forward());
      check_output("cyc_timeout", memory_timeout, m_timeout);
      check_output("cyc_stall_cycles", stall_cycles, m_stalls);
      check_output("cyc_flush_events", flush_events, m_flushes);
    end
  end

  task automatic apply_stimulus();
    decode_read_address      = '0;
    decode_read_used         = '0;
    execution_read_address   = '0;
    execution_read_used      = '0;
    execution_register_write = 1'b0;
    execution_memory_read    = 1'b0;
    execution_write_address  = '0;
    memory_register_write    = 1'b0;
    memory_write_address     = '0;
    writeback_register_write = 1'b0;
    writeback_write_address  = '0;
    redirect                 = 1'b0;
    memory_request           = 1'b0;
    memory_ready             = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge system_clock);
    #1;
  endtask

  task automatic load_use_on_port1();
    execution_memory_read    = 1'b1;
    execution_register_write = 1'b1;
    execution_write_address  = 5'd8;
    decode_read_address      = {5'd8, 5'd3};
    decode_read_used         = 2'b10;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    apply_stimulus();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_output("rst_stall_cycles", stall_cycles, 0);
    check_output("rst_flush_events", flush_events, 0);
    check_output("rst_flush", flush, 0);
    check_output("rst_timeout", memory_timeout, 0);

    load_use_on_port1();
    #1;
    check_output("lu_stall", stall_fetch_decode, 1);
    check_output("lu_bubble", bubble_execution, 1);
    check_output("lu_stall_cycles_before", stall_cycles, 0);
    next_cycle();
    execution_write_address = 5'd0;
    decode_read_address     = {5'd0, 5'd0};
    decode_read_used        = 2'b11;
    #1;
    check_output("lu_r0_no_stall", stall_fetch_decode, 0);
    check_output("lu_stall_cycles_after", stall_cycles, 1);
    next_cycle();
    apply_stimulus();

    memory_register_write    = 1'b1;
    memory_write_address     = 5'd5;
    writeback_register_write = 1'b1;
    writeback_write_address  = 5'd5;
    execution_read_address   = {5'd0, 5'd5};
    execution_read_used      = 2'b11;
    #1;
    check_output("fwd_mem_wins", forward_select, 4'b0001);
    memory_register_write = 1'b0;
    #1;
    check_output("fwd_wb", forward_select, 4'b0010);
    execution_read_used = 2'b10;
    #1;
    check_output("fwd_unused", forward_select, 4'b0000);
    memory_register_write   = 1'b1;
    memory_write_address    = 5'd9;
    writeback_write_address = 5'd7;
    execution_read_address  = {5'd7, 5'd9};
    execution_read_used     = 2'b11;
    #1;
    check_output("fwd_two_ports", forward_select, 4'b1001);
    next_cycle();
    apply_stimulus();

    redirect = 1'b1;
    #1;
    check_output("rd_latency", flush, 0);
    next_cycle();
    redirect = 1'b0;
    load_use_on_port1();
    #1;
    check_output("rd_flush", flush, 3'b111);
    check_output("rd_events", flush_events, 1);
    check_output("rd_stall_suppressed", stall_fetch_decode, 0);
    next_cycle();
    apply_stimulus();
    #1;
    check_output("rd_one_cycle", flush, 0);
    redirect = 1'b1;
    next_cycle();
    check_output("rd_b2b_first", flush, 3'b111);
    check_output("rd_b2b_events1", flush_events, 2);
    next_cycle();
    redirect = 1'b0;
    #1;
    check_output("rd_b2b_second", flush, 3'b111);
    check_output("rd_b2b_events2", flush_events, 3);
    next_cycle();
    check_output("rd_b2b_end", flush, 0);

    memory_request = 1'b1;
    memory_ready   = 1'b0;
    #1;
    check_output("hold_active", hold_all, 1);
    next_cycle();
    redirect = 1'b1;
    next_cycle();
    redirect = 1'b0;
    #1;
    check_output("hold_no_flush", flush, 0);
    next_cycle();
    next_cycle();
    memory_ready = 1'b1;
    #1;
    check_output("hold_released", hold_all, 0);
    check_output("hold_flush_deferred", flush, 0);
    check_output("hold_stall_cycles", stall_cycles, 5);
    next_cycle();
    memory_request = 1'b0;
    memory_ready   = 1'b0;
    #1;
    check_output("hold_pending_flush", flush, 3'b111);
    check_output("hold_events", flush_events, 4);
    next_cycle();
    check_output("hold_flush_end", flush, 0);

    memory_request = 1'b1;
    memory_ready   = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      if (k == 7) check_output("to_before", memory_timeout, 0);
      if (k == 8) check_output("to_set", memory_timeout, 1);
    end
    check_output("to_stall_saturated", stall_cycles, CMAX);
    memory_ready = 1'b1;
    next_cycle();
    apply_stimulus();
    next_cycle();
    check_output("to_sticky", memory_timeout, 1);

    memory_request = 1'b1;
    redirect       = 1'b1;
    next_cycle();
    redirect = 1'b0;
    reset    = 1'b1;
    next_cycle();
    reset          = 1'b0;
    memory_request = 1'b0;
    #1;
    check_output("rp_stall_cycles", stall_cycles, 0);
    check_output("rp_events", flush_events, 0);
    check_output("rp_timeout", memory_timeout, 0);
    next_cycle();
    check_output("rp_no_flush", flush, 0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
